// File: rtl/systolic_bs_array_if.sv
// Job/stream bundle for the bit-serial systolic array: control, beat stream and results.
// A beat transfers on a rising edge where in_valid && in_ready; in_valid may drop at any time (bubble) and in_ready is only high while a job is running.
interface systolic_bs_array_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32
) ();
    logic                          start;
    logic [3:0]                    precision;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [ROWS*ACT_WIDTH-1:0]     act_in;
    logic [COLS-1:0]               w_in;
    logic                          busy;
    logic                          done;
    logic                          err;
    logic [ROWS*COLS*ACC_WIDTH-1:0] acc_out;
    logic [ROWS-1:0]               active_row;
    logic [COLS-1:0]               active_column;
    logic [1:0]                    fsm_state;

    modport master (
        output start, precision, in_valid, in_last, act_in, w_in,
        input  in_ready, busy, done, err, acc_out, active_row, active_column, fsm_state
    );

    modport slave (
        input  start, precision, in_valid, in_last, act_in, w_in,
        output in_ready, busy, done, err, acc_out, active_row, active_column, fsm_state
    );
endinterface

// File: rtl/systolic_bs_array.sv
// Output-stationary bit-serial systolic array: activations flow right, MSB-first weight bits
// and their tags flow down, each PE accumulates a*w by shift-and-add over precision beats.
module systolic_bs_array #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int PREC_MAX  = 8
) (
    input logic                   clk,
    input logic                   rst,
    systolic_bs_array_if.slave    bus
);
    localparam int PW        = ACT_WIDTH + PREC_MAX;
    localparam int DRAIN_LEN = ROWS + COLS;
    localparam int CW        = $clog2(DRAIN_LEN + 1);
    localparam logic [3:0] PREC_MAX_L = 4'(PREC_MAX);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      prec_q;
    logic [3:0]      bit_cnt_q;
    logic [CW-1:0]   drain_cnt_q;
    logic            err_q;
    logic            prec_ok, start_ok, start_bad, accept, tag_first, tag_last;

    // Slot (r,c) holds what enters PE(r,c); tags are {b, valid, first, last}.
    logic [ROWS*COLS*ACT_WIDTH-1:0] a_pipe;
    logic [ROWS*COLS*4-1:0]         t_pipe;

    always_comb begin
        prec_ok   = (bus.precision != 4'd0) && (bus.precision <= PREC_MAX_L);
        start_ok  = (state_q == S_IDLE) && bus.start && prec_ok;
        start_bad = (state_q == S_IDLE) && bus.start && !prec_ok;
        accept    = bus.in_valid && (state_q == S_RUN);
        tag_first = (bit_cnt_q == 4'd0);
        tag_last  = (bit_cnt_q == prec_q - 4'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (accept && tag_last && bus.in_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_cnt_q == CW'(DRAIN_LEN - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_RUN);
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.fsm_state = state_q;
    end

    assign bus.err = err_q;

    // Drain lasts ROWS+COLS cycles so the far corner PE has absorbed the final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prec_q      <= '0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                prec_q    <= bus.precision;
                bit_cnt_q <= '0;
            end else if (accept) begin
                bit_cnt_q <= tag_last ? 4'd0 : bit_cnt_q + 4'd1;
            end
            drain_cnt_q <= (state_q == S_DRAIN) ? drain_cnt_q + CW'(1) : '0;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_rskew
        logic signed [ACT_WIDTH-1:0] sr_q [r+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i <= r; i++) sr_q[i] <= '0;
            end else begin
                sr_q[0] <= bus.act_in[r*ACT_WIDTH +: ACT_WIDTH];
                for (int i = 1; i <= r; i++) sr_q[i] <= sr_q[i-1];
            end
        end
        assign a_pipe[(r*COLS)*ACT_WIDTH +: ACT_WIDTH] = sr_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cskew
        logic [3:0] cs_q [c+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i <= c; i++) cs_q[i] <= '0;
            end else begin
                cs_q[0] <= {bus.w_in[c], accept, accept && tag_first, accept && tag_last};
                for (int i = 1; i <= c; i++) cs_q[i] <= cs_q[i-1];
            end
        end
        assign t_pipe[c*4 +: 4] = cs_q[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [ACT_WIDTH-1:0] a_in;
            logic [3:0]                  t_in;
            logic signed [PW-1:0]        a_ext, partial_q, partial_d;
            logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

            assign a_in  = a_pipe[(r*COLS+c)*ACT_WIDTH +: ACT_WIDTH];
            assign t_in  = t_pipe[(r*COLS+c)*4 +: 4];
            assign a_ext = PW'(a_in);

            // MSB carries negative weight, so the first beat seeds the partial with -a.
            always_comb begin
                partial_d = partial_q;
                acc_d     = acc_q;
                if (t_in[2]) begin
                    if (t_in[1]) partial_d = t_in[3] ? -a_ext : '0;
                    else         partial_d = (partial_q <<< 1) + (t_in[3] ? a_ext : '0);
                    if (t_in[0]) acc_d = acc_q + ACC_WIDTH'(partial_d);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    partial_q <= '0;
                    acc_q     <= '0;
                end else if (start_ok) begin
                    partial_q <= '0;
                    acc_q     <= '0;
                end else begin
                    partial_q <= partial_d;
                    acc_q     <= acc_d;
                end
            end

            assign bus.acc_out[(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH] = acc_q;

            if (c == 0) begin : g_act_row
                assign bus.active_row[r] = t_in[2];
            end
            if (r == 0) begin : g_act_col
                assign bus.active_column[c] = t_in[2];
            end

            if (c < COLS - 1) begin : g_fwd_a
                logic signed [ACT_WIDTH-1:0] a_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) a_q <= '0;
                    else      a_q <= a_in;
                end
                assign a_pipe[(r*COLS+c+1)*ACT_WIDTH +: ACT_WIDTH] = a_q;
            end

            if (r < ROWS - 1) begin : g_fwd_t
                logic [3:0] t_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) t_q <= '0;
                    else      t_q <= t_in;
                end
                assign t_pipe[((r+1)*COLS+c)*4 +: 4] = t_q;
            end
        end
    end
endmodule
